systolic_array_ws: RTL and testbench
====================================

# systolic_array_ws

Parametrised weight-stationary systolic array, ROWS x COLS signed-integer PEs, successor to the fixed 4x4 array. Adds internal input skewing and output deskewing, so callers present one unskewed activation vector per cycle and receive one aligned result vector per cycle. Also adds a valid/ready handshake for weight loading and for activation streaming, plus a drain-before-reload state machine. Sits between the activation buffer and the accumulator/writeback stage of the accelerator datapath.

## Interface
- WIDTH, 8, activation/weight width, signed two's complement
- ACCUMULATE, 32, partial-sum and result width, signed
- ROWS, 4, PE rows, equal to activation vector length; ≥1
- COLS, 4, PE columns, equal to result vector length; ≥1

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- w_valid  in  1  weight row offered
- w_ready  out  1  weight row accepted when w_valid && w_ready
- w_data  in  COLS*WIDTH  lane c = W[r][c], where r = internal row counter
- in_valid  in  1  activation vector offered
- in_ready  out  1  vector accepted when in_valid && in_ready
- in_data  in  ROWS*WIDTH  lane r = a[r]
- out_valid  out  1  result vector valid, single-cycle pulse per accepted vector
- out_data  out  COLS*ACCUMULATE  lane c = sum over r of a[r]*W[r][c]
- busy  out  1  high in DRAIN or while any accepted vector is still in flight

## Operation
- PE(r,c): holds weight W[r][c]; each cycle registers east = west and south = north + west*weight. North input of row 0 is 0.
- Skew: row r activation passes through r registers before entering PE(r,0). Deskew: column c result passes through COLS-1-c registers, then through one output register.
- Cycles with no accepted vector inject zeros into the skew chains. A parallel valid shift register of length L = ROWS+COLS-1 produces out_valid.
- FSM states:
  - LOAD: w_ready=1, in_ready=0. Each accepted row writes W[cnt][*], then cnt++. After row ROWS-1, cnt=0 and the FSM goes to STREAM.
  - STREAM: in_ready=1, w_ready=0. If w_valid=1, the FSM goes to DRAIN. An in_valid in that same cycle is still accepted; the w_valid is not consumed.
  - DRAIN: in_ready=0, w_ready=0. Once the valid pipeline is empty, including the vector accepted on the exit cycle, the FSM goes to LOAD.
- Weights are never changed while any vector is in flight.
- Arithmetic: WIDTH x WIDTH signed product, sign-extended to ACCUMULATE. Add wraps modulo 2^ACCUMULATE unless saturation is enabled.
- There is no output backpressure. The consumer must accept out_valid every cycle.

## Timing
- Reset values:
  - state=LOAD, cnt=0, all weights 0, skew/deskew/PE registers 0
  - out_valid=0, out_data=0, busy=0, w_ready=1, in_ready=0
- Latency: a vector accepted at edge k produces out_valid=1 and out_data after edge k+L. For 4x4, L=7.
- Throughput: one vector per cycle in STREAM. Back-to-back results emerge on consecutive cycles.
- out_data holds its last value while out_valid=0.
- Reset asserted mid-operation: every in-flight result is discarded. No out_valid is asserted for those results after reset.
- Reload: the first result of the new weights is never mixed with the old weights.
- LOAD with partial rows: rows not yet rewritten keep their previous values until written.

## Configuration
- SYSTOLIC_SATURATE_EN defined: every PE add clamps to the range [-2^(ACCUMULATE-1), 2^(ACCUMULATE-1)-1].
- SYSTOLIC_SATURATE_EN undefined: every PE add wraps modulo 2^ACCUMULATE.
- Latency is identical in both configurations.

## Test plan
- Identity load: load 4x4 W = I, then stream [1,2,3,4]. Required: out_valid 7 cycles after acceptance, out_data=[1,2,3,4].
- Back-to-back: W[r][c]=r+1; stream [1,1,1,1], [2,0,0,0], [0,0,0,3] on consecutive cycles. Required: results [10,10,10,10], [2,2,2,2], [12,12,12,12] on three consecutive cycles.
- Negative values: W all 8'hFF (-1), input all 127. Required: every lane = -508.
- Overflow, ACCUMULATE=16, W all 127, input all 127:
  - Without macro: every lane = -1020.
  - With SYSTOLIC_SATURATE_EN: every lane = 32767.
- Reload mid-stream: raise w_valid while 3 vectors are in flight. Required:
  - All 3 results are emitted with the old weights.
  - busy stays high until the last of those results.
  - w_ready rises only after the pipeline is empty.
  - A vector streamed after the reload uses only the new weights.
- Reset mid-stream: assert reset 2 cycles after accepting a vector. Required: no out_valid follows, state=LOAD, all weights read back 0, which is checked by loading nothing and streaming after a full load of zeros.

Source files
------------

// File: rtl/systolic_array_ws.sv
// systolic_array_ws: weight-stationary ROWS x COLS signed MAC array.
// Callers present one unskewed activation vector per cycle; the array skews
// it internally, and deskews the column sums into one aligned result vector.
// Weights load one row per w_valid/w_ready beat; a reload request while
// streaming drains every in-flight vector before the weights may change.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; ready never depends on valid, and data is sampled only on that edge.
// Optional build macro: SYSTOLIC_SATURATE_EN (clamp every PE add instead of wrapping).
module systolic_array_ws #(
    parameter int WIDTH      = 8,
    parameter int ACCUMULATE = 32,
    parameter int ROWS       = 4,
    parameter int COLS       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [COLS*WIDTH-1:0]      w_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*WIDTH-1:0]      in_data,
    output logic                       out_valid,
    output logic [COLS*ACCUMULATE-1:0] out_data,
    output logic                       busy,
    output logic [1:0]                 o_dbg_state
);
    localparam int L     = ROWS + COLS - 1;
    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [CNT_W-1:0]              r_cnt;
    logic                          w_in_acc;
    logic                          w_w_acc;
    logic [L-1:0]                  r_vld;
    logic                          r_out_valid;
    logic [COLS*ACCUMULATE-1:0]    r_out_data;
    logic signed [WIDTH-1:0]       r_weight   [ROWS][COLS];
    logic signed [WIDTH-1:0]       r_east     [ROWS][COLS];
    logic signed [ACCUMULATE-1:0]  r_south    [ROWS][COLS];
    logic signed [WIDTH-1:0]       w_pe_west  [ROWS][COLS];
    logic signed [ACCUMULATE-1:0]  w_pe_north [ROWS][COLS];
    logic signed [WIDTH-1:0]       w_west0    [ROWS];
    logic signed [ACCUMULATE-1:0]  w_col_res  [COLS];

    // One PE step: north + west*weight, product sign-extended, wrap or clamp.
    function automatic logic signed [ACCUMULATE-1:0] pe_add(
        input logic signed [ACCUMULATE-1:0] north,
        input logic signed [WIDTH-1:0]      west,
        input logic signed [WIDTH-1:0]      weight
    );
        logic signed [2*WIDTH-1:0]    prod;
        logic signed [ACCUMULATE:0]   sum;
        prod = west * weight;
        sum  = (ACCUMULATE+1)'(north) + (ACCUMULATE+1)'(prod);
`ifdef SYSTOLIC_SATURATE_EN
        if (sum[ACCUMULATE] != sum[ACCUMULATE-1]) begin
            return sum[ACCUMULATE] ? {1'b1, {(ACCUMULATE-1){1'b0}}}
                                   : {1'b0, {(ACCUMULATE-1){1'b1}}};
        end
        return sum[ACCUMULATE-1:0];
`else
        return sum[ACCUMULATE-1:0];
`endif
    endfunction

    assign w_in_acc    = in_valid && in_ready;
    assign w_w_acc     = w_valid && w_ready;
    assign busy        = (r_state == S_DRAIN) || (|r_vld);
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign o_dbg_state = r_state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_LOAD;
        else       r_state <= w_state_nxt;
    end

    // Next-state and ready decode; DRAIN waits until no accepted vector remains.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        in_ready    = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_ready = 1'b1;
                if (w_valid && (r_cnt == CNT_W'(ROWS-1))) w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                in_ready = 1'b1;
                if (w_valid) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (~|r_vld) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Weight row counter and weight storage; unwritten rows keep their values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    r_weight[r][c] <= '0;
        end else if (w_w_acc) begin
            r_cnt <= (r_cnt == CNT_W'(ROWS-1)) ? '0 : r_cnt + 1'b1;
            for (int r = 0; r < ROWS; r++)
                if (r_cnt == CNT_W'(r))
                    for (int c = 0; c < COLS; c++)
                        r_weight[r][c] <= w_data[c*WIDTH +: WIDTH];
        end
    end

    // Input skew: row r is delayed r cycles; idle cycles inject zeros.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_skew
        logic signed [WIDTH-1:0] w_a;
        assign w_a = w_in_acc ? in_data[gr*WIDTH +: WIDTH] : '0;
        if (gr == 0) begin : g_direct
            assign w_west0[gr] = w_a;
        end else begin : g_chain
            logic signed [WIDTH-1:0] r_skew [gr];
            // Shift the row's activation toward PE(gr,0).
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j < gr; j++) r_skew[j] <= '0;
                end else begin
                    r_skew[0] <= w_a;
                    for (int j = 1; j < gr; j++) r_skew[j] <= r_skew[j-1];
                end
            end
            assign w_west0[gr] = r_skew[gr-1];
        end
    end

    // PE neighbour wiring: west from the skew chain or left PE, north from the PE above.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            w_pe_west[r][0] = w_west0[r];
            for (int c = 1; c < COLS; c++) w_pe_west[r][c] = r_east[r][c-1];
        end
        for (int c = 0; c < COLS; c++) begin
            w_pe_north[0][c] = '0;
            for (int r = 1; r < ROWS; r++) w_pe_north[r][c] = r_south[r-1][c];
        end
    end

    // PE registers: pass activation east, accumulate partial sum south.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    r_east[r][c]  <= '0;
                    r_south[r][c] <= '0;
                end
        end else begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    r_east[r][c]  <= w_pe_west[r][c];
                    r_south[r][c] <= pe_add(w_pe_north[r][c], w_pe_west[r][c], r_weight[r][c]);
                end
        end
    end

    // Output deskew: column c is delayed COLS-1-c cycles so all lanes line up.
    for (genvar gc = 0; gc < COLS; gc++) begin : g_deskew
        localparam int D = COLS - 1 - gc;
        if (D == 0) begin : g_direct
            assign w_col_res[gc] = r_south[ROWS-1][gc];
        end else begin : g_chain
            logic signed [ACCUMULATE-1:0] r_dsk [D];
            // Shift the column result toward the output register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j < D; j++) r_dsk[j] <= '0;
                end else begin
                    r_dsk[0] <= r_south[ROWS-1][gc];
                    for (int j = 1; j < D; j++) r_dsk[j] <= r_dsk[j-1];
                end
            end
            assign w_col_res[gc] = r_dsk[D-1];
        end
    end

    // Valid pipeline tracks accepted vectors; output register holds between results.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_vld       <= (r_vld << 1) | L'(w_in_acc);
            r_out_valid <= r_vld[L-1];
            if (r_vld[L-1])
                for (int c = 0; c < COLS; c++)
                    r_out_data[c*ACCUMULATE +: ACCUMULATE] <= w_col_res[c];
        end
    end

endmodule

// File: tb/tb_systolic_array_ws.sv
// Bench for systolic_array_ws (4x4, 8-bit operands, 16-bit accumulate so
// the overflow behaviour is reachable). Honours SYSTOLIC_SATURATE_EN.
module tb_systolic_array_ws;
  localparam int WIDTH = 8;
  localparam int ACC   = 16;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int L     = ROWS + COLS - 1;
  localparam longint SMAX = (64'sd1 <<< (ACC-1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (ACC-1));

  typedef logic [ROWS*COLS-1:0][WIDTH-1:0] wmat_t;
  typedef logic [ROWS-1:0][WIDTH-1:0]      avec_t;
  typedef logic [COLS-1:0][ACC-1:0]        rvec_t;
  typedef struct packed {
    logic  new_w;
    wmat_t w;
    avec_t a;
    rvec_t e;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                  w_valid, w_ready, in_valid, in_ready, out_valid, busy;
  logic [COLS*WIDTH-1:0] w_data;
  logic [ROWS*WIDTH-1:0] in_data;
  logic [COLS*ACC-1:0]   out_data;
  logic [1:0]            dbg_state;

  systolic_array_ws #(.WIDTH(WIDTH), .ACCUMULATE(ACC), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .busy(busy),
    .o_dbg_state(dbg_state)
  );

  // scoreboard
  logic [COLS*ACC-1:0] exp_q[$];
  int                  exp_cyc_q[$];
  logic [COLS*ACC-1:0] last_out;
  wmat_t               cur_w;
  int                  total = 0;
  int                  bad   = 0;
  vec_t                tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=handshake (cycle %0d)", name, cyc);
  endtask

  // Reference: column c = sum_r a[r]*W[r][c], each add wrapped or clamped in row order.
  function automatic rvec_t model(input wmat_t w, input avec_t a);
    rvec_t res;
    for (int c = 0; c < COLS; c++) begin
      longint acc = 0;
      for (int r = 0; r < ROWS; r++) begin
        acc = acc + longint'($signed(a[r])) * longint'($signed(w[r*COLS+c]));
`ifdef SYSTOLIC_SATURATE_EN
        if (acc > SMAX) acc = SMAX;
        if (acc < SMIN) acc = SMIN;
`endif
      end
      res[c] = acc[ACC-1:0];
    end
    return res;
  endfunction

  function automatic wmat_t w_fill(input int v);
    wmat_t w;
    for (int i = 0; i < ROWS*COLS; i++) w[i] = WIDTH'(v);
    return w;
  endfunction

  function automatic wmat_t w_identity();
    wmat_t w;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) w[r*COLS+c] = (r == c) ? 8'd1 : 8'd0;
    return w;
  endfunction

  function automatic wmat_t w_rowplus1();
    wmat_t w;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) w[r*COLS+c] = WIDTH'(r + 1);
    return w;
  endfunction

  function automatic wmat_t w_rand();
    wmat_t w;
    for (int i = 0; i < ROWS*COLS; i++) w[i] = WIDTH'($urandom_range(0, 255));
    return w;
  endfunction

  function automatic avec_t vec4(input int a0, input int a1, input int a2, input int a3);
    avec_t a;
    a[0] = WIDTH'(a0); a[1] = WIDTH'(a1); a[2] = WIDTH'(a2); a[3] = WIDTH'(a3);
    return a;
  endfunction

  function automatic avec_t a_rand();
    avec_t a;
    for (int r = 0; r < ROWS; r++) a[r] = WIDTH'($urandom_range(0, 255));
    return a;
  endfunction

  function automatic rvec_t res4(input longint e0, input longint e1, input longint e2, input longint e3);
    rvec_t e;
    e[0] = e0[ACC-1:0]; e[1] = e1[ACC-1:0]; e[2] = e2[ACC-1:0]; e[3] = e3[ACC-1:0];
    return e;
  endfunction

  // One clock: advance to the next falling edge, then check the output port.
  task automatic tick();
    logic [COLS*ACC-1:0] d;
    int ec;
    @(negedge clk);
    if (reset) begin
      last_out = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid actual=1 required=0 data=%0h (cycle %0d)", out_data, cyc);
      end else begin
        d  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("out_data", out_data, d);
        check("out_latency", 64'(cyc), 64'(ec));
      end
      last_out = out_data;
    end else begin
      check("out_hold", out_data, last_out);
    end
  endtask

  // driver: one weight row per accepted beat; ends with all ROWS rows written.
  task automatic load_weights(input wmat_t w);
    int row = 0;
    int guard = 0;
    logic [COLS-1:0][WIDTH-1:0] rowd;
    while (row < ROWS && guard < 100) begin
      for (int c = 0; c < COLS; c++) rowd[c] = w[row*COLS+c];
      w_valid = 1'b1;
      w_data  = rowd;
      if (exp_q.size() != 0) begin
        check("busy_in_flight", 64'(busy), 64'd1);
        check("w_ready_in_flight", 64'(w_ready), 64'd0);
      end
      if (w_ready) begin
        check("in_ready_in_load", 64'(in_ready), 64'd0);
        row++;
      end
      tick();
      guard++;
    end
    w_valid = 1'b0;
    if (row != ROWS) fail("load_timeout");
    cur_w = w;
  endtask

  // driver: offer one vector until accepted; expectation due L edges after acceptance.
  task automatic stream_vec(input avec_t a, input rvec_t e);
    int guard = 0;
    logic acc = 1'b0;
    while (!acc && guard < 50) begin
      in_valid = 1'b1;
      in_data  = a;
      acc = in_ready;
      if (acc) begin
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 1 + L);
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) fail("stream_timeout");
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 4*L) begin
      tick();
      g++;
    end
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    wmat_t nw;
    avec_t a;
    reset = 1'b1; w_valid = 1'b0; w_data = '0; in_valid = 1'b0; in_data = '0;
    cur_w = '0; last_out = '0;

    tbl[0] = '{new_w: 1'b1, w: w_identity(), a: vec4(1, 2, 3, 4), e: res4(1, 2, 3, 4)};
    tbl[1] = '{new_w: 1'b1, w: w_rowplus1(), a: vec4(1, 1, 1, 1), e: res4(10, 10, 10, 10)};
    tbl[2] = '{new_w: 1'b0, w: w_rowplus1(), a: vec4(2, 0, 0, 0), e: res4(2, 2, 2, 2)};
    tbl[3] = '{new_w: 1'b0, w: w_rowplus1(), a: vec4(0, 0, 0, 3), e: res4(12, 12, 12, 12)};
    tbl[4] = '{new_w: 1'b1, w: w_fill(255), a: vec4(127, 127, 127, 127), e: res4(-508, -508, -508, -508)};
`ifdef SYSTOLIC_SATURATE_EN
    tbl[5] = '{new_w: 1'b1, w: w_fill(127), a: vec4(127, 127, 127, 127), e: res4(32767, 32767, 32767, 32767)};
`else
    tbl[5] = '{new_w: 1'b1, w: w_fill(127), a: vec4(127, 127, 127, 127), e: res4(-1020, -1020, -1020, -1020)};
`endif

    // reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_w_ready", 64'(w_ready), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);

    // table: identity, back-to-back, negative, overflow
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].new_w) load_weights(tbl[i].w);
      stream_vec(tbl[i].a, tbl[i].e);
    end
    drain();

    // reload requested on the same cycle as the third of three vectors
    load_weights(w_rowplus1());
    a = a_rand(); stream_vec(a, model(cur_w, a));
    a = a_rand(); stream_vec(a, model(cur_w, a));
    nw = w_rand();
    a = a_rand();
    in_valid = 1'b1; in_data = a;
    w_valid = 1'b1; w_data = nw[COLS-1:0];
    check("exit_in_ready", 64'(in_ready), 64'd1);
    check("exit_w_ready", 64'(w_ready), 64'd0);
    exp_q.push_back(model(cur_w, a));
    exp_cyc_q.push_back(cyc + 1 + L);
    tick();
    in_valid = 1'b0;
    check("in_flight_count", 64'(exp_q.size()), 64'd3);
    check("drain_state", 64'(dbg_state), 64'd2);
    load_weights(nw);
    a = a_rand(); stream_vec(a, model(cur_w, a));
    drain();

    // randomized rounds with reloads from STREAM
    for (int round = 0; round < 3; round++) begin
      load_weights(w_rand());
      for (int n = 0; n < 30; n++) begin
        if ($urandom_range(0, 3) == 0) tick();
        else begin
          a = a_rand();
          stream_vec(a, model(cur_w, a));
        end
      end
    end
    drain();

    // reset two cycles after accepting a vector
    load_weights(w_rand());
    a = a_rand(); stream_vec(a, model(cur_w, a));
    tick();
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    check("mid_rst_w_ready", 64'(w_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    repeat (L + 3) tick();
    cur_w = '0;
    load_weights(w_fill(0));
    a = a_rand(); stream_vec(a, model(cur_w, a));
    a = a_rand(); stream_vec(a, model(cur_w, a));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
